// File: rtl/rv32_pkg.sv
// Shared RV32I constants and types for the register-file writeback path.
//   XLEN / NREG / AW : data width, architectural register count, address width
//   wb_req_t         : one writeback request (valid, destination, payload)
//   wb_src_e         : identifies which writeback requester owns the port
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   i_clk, i_reset : clock, asynchronous active-low reset
//   req_i[1:0]     : request vector, bit 0 = ALU, bit 1 = LSU
//   gnt_o[1:0]     : one-hot combinational grant (all zero when no request)
// The pointer remembers the last source granted. When both sources request,
// the other one wins, so back-to-back contention alternates.
module rr_arb2
  import rv32_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  wb_src_e last_q, last_d;

  // State register. Resetting "last" to LSU makes ALU the first winner.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      last_q <= SRC_LSU;
    end else begin
      last_q <= last_d;
    end
  end

  // Next state: follow whichever source was just granted.
  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = SRC_ALU;
    end else if (gnt_o[1]) begin
      last_d = SRC_LSU;
    end
  end

  // Output: a lone requester always wins; under contention, the one not
  // granted last wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == SRC_ALU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: owns the single regfile write port.
//   i_clk, i_reset          : clock, asynchronous active-low reset
//   i_flush                 : clears the busy scoreboard, blocks issue this cycle
//   i_issue_* / o_issue_ready : decode-side hazard check and busy-bit set
//   i_alu_wb_* / o_alu_wb_ready : ALU writeback request and grant
//   i_lsu_wb_* / o_lsu_wb_ready : LSU writeback request and grant
//   o_rd_wren/addr/data     : registered regfile write pins
//   o_idle                  : nothing busy, nothing committing, nothing requesting
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1. Issue ready is a pure hazard check and never looks at valid.
// Writeback ready is the arbiter grant; a requester holds valid and payload
// stable until it sees ready, and may change them after the accepting edge.
module rf_wb_scheduler
  import rv32_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG_P = NREG,
  parameter int AW_P   = AW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_issue_valid,
  input  logic [AW_P-1:0]   i_issue_rs1,
  input  logic [AW_P-1:0]   i_issue_rs2,
  input  logic              i_issue_use_rs1,
  input  logic              i_issue_use_rs2,
  input  logic              i_issue_wren,
  input  logic [AW_P-1:0]   i_issue_rd,
  output logic              o_issue_ready,
  input  logic              i_alu_wb_valid,
  input  logic [AW_P-1:0]   i_alu_wb_rd,
  input  logic [XLEN_P-1:0] i_alu_wb_data,
  output logic              o_alu_wb_ready,
  input  logic              i_lsu_wb_valid,
  input  logic [AW_P-1:0]   i_lsu_wb_rd,
  input  logic [XLEN_P-1:0] i_lsu_wb_data,
  output logic              o_lsu_wb_ready,
  output logic              o_rd_wren,
  output logic [AW_P-1:0]   o_rd_addr,
  output logic [XLEN_P-1:0] o_rd_data,
  output logic              o_idle
);

  logic [NREG_P-1:0] busy_q, busy_d;
  logic              wren_q;
  logic [AW_P-1:0]   addr_q;
  logic [XLEN_P-1:0] data_q;

  logic              hazard;
  logic              issue_fire;
  logic [1:0]        gnt;
  logic [AW_P-1:0]   sel_rd;
  logic [XLEN_P-1:0] sel_data;

  // ---------------------------------------------------------------- scoreboard
  // Only the registered busy vector is consulted, so a commit landing this
  // edge unblocks the dependent instruction on the following cycle, by which
  // time the regfile already holds the value.
  always_comb begin
    hazard = (i_issue_use_rs1 & busy_q[i_issue_rs1])
           | (i_issue_use_rs2 & busy_q[i_issue_rs2])
           | (i_issue_wren & (i_issue_rd != '0) & busy_q[i_issue_rd]);
  end

  assign o_issue_ready = ~hazard;
  assign issue_fire    = i_issue_valid & o_issue_ready & ~i_flush;

  // Clear first, then set, so a same-register set/clear pair leaves it busy.
  // Flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (wren_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (issue_fire && i_issue_wren && (i_issue_rd != '0)) begin
      busy_d[i_issue_rd] = 1'b1;
    end
    if (i_flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // --------------------------------------------------------------- arbitration
  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .req_i   ({i_lsu_wb_valid, i_alu_wb_valid}),
    .gnt_o   (gnt)
  );

  assign o_alu_wb_ready = gnt[0];
  assign o_lsu_wb_ready = gnt[1];

  always_comb begin
    sel_rd   = gnt[1] ? i_lsu_wb_rd   : i_alu_wb_rd;
    sel_data = gnt[1] ? i_lsu_wb_data : i_alu_wb_data;
  end

  // -------------------------------------------------------------------- commit
  // A granted rd=0 request is consumed but never raises the write enable.
  // Flush does not touch this register: late results still land.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wren_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (|gnt) begin
      wren_q <= (sel_rd != '0);
      addr_q <= sel_rd;
      data_q <= sel_data;
    end else begin
      wren_q <= 1'b0;
    end
  end

  assign o_rd_wren = wren_q;
  assign o_rd_addr = addr_q;
  assign o_rd_data = data_q;

  assign o_idle = ~(|busy_q) & ~wren_q & ~i_alu_wb_valid & ~i_lsu_wb_valid;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

  // ------------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 0;
  logic        iss_v = 0, iss_u1 = 0, iss_u2 = 0, iss_w = 0;
  logic [4:0]  iss_rs1 = 0, iss_rs2 = 0, iss_rd = 0;
  logic        iss_rdy;
  logic        alu_v = 0, lsu_v = 0;
  logic [4:0]  alu_rd = 0, lsu_rd = 0;
  logic [31:0] alu_dat = 0, lsu_dat = 0;
  logic        alu_rdy, lsu_rdy;
  logic        rd_wren, idle;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  rf_wb_scheduler dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_flush         (flush),
    .i_issue_valid   (iss_v),
    .i_issue_rs1     (iss_rs1),
    .i_issue_rs2     (iss_rs2),
    .i_issue_use_rs1 (iss_u1),
    .i_issue_use_rs2 (iss_u2),
    .i_issue_wren    (iss_w),
    .i_issue_rd      (iss_rd),
    .o_issue_ready   (iss_rdy),
    .i_alu_wb_valid  (alu_v),
    .i_alu_wb_rd     (alu_rd),
    .i_alu_wb_data   (alu_dat),
    .o_alu_wb_ready  (alu_rdy),
    .i_lsu_wb_valid  (lsu_v),
    .i_lsu_wb_rd     (lsu_rd),
    .i_lsu_wb_data   (lsu_dat),
    .o_lsu_wb_ready  (lsu_rdy),
    .o_rd_wren       (rd_wren),
    .o_rd_addr       (rd_addr),
    .o_rd_data       (rd_data),
    .o_idle          (idle)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------- reference model
  // In-flight set of destination registers, who won the port last, and what
  // the regfile is being told to write this cycle.
  bit          m_busy[32];
  bit          m_last_lsu;
  bit          m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [36:0] exp_q[$];

  function automatic bit m_ready();
    bit h;
    h = (iss_u1 && m_busy[iss_rs1]) || (iss_u2 && m_busy[iss_rs2]) ||
        (iss_w && iss_rd != 0 && m_busy[iss_rd]);
    return !h;
  endfunction

  function automatic bit [1:0] m_grant();
    if (alu_v && lsu_v) return m_last_lsu ? 2'b01 : 2'b10;
    return {lsu_v, alu_v};
  endfunction

  function automatic bit m_idle();
    bit any;
    any = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) any = 1;
    return !any && !m_wren && !alu_v && !lsu_v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_last_lsu = 1;
        m_wren = 0;
        m_addr = 0;
        m_data = 0;
        exp_q.delete();
      end else begin
        bit [1:0]    g;
        bit          fire;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        g = m_grant();
        fire = iss_v && m_ready() && !flush;
        if (m_wren) m_busy[m_addr] = 0;
        if (fire && iss_w && iss_rd != 0) m_busy[iss_rd] = 1;
        if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
        if (g != 0) begin
          wrd  = g[1] ? lsu_rd : alu_rd;
          wdat = g[1] ? lsu_dat : alu_dat;
          m_last_lsu = g[1];
          m_wren = (wrd != 0);
          m_addr = wrd;
          m_data = wdat;
          if (wrd != 0) exp_q.push_back({wrd, wdat});
        end else begin
          m_wren = 0;
        end
      end
    end
  end

  // ------------------------------------------------- per-cycle compare process
  initial begin
    forever begin
      @(negedge clk);
      check("issue_ready", 32'(iss_rdy), 32'(m_ready()));
      check("alu_ready", 32'(alu_rdy), 32'(m_grant() == 2'b01));
      check("lsu_ready", 32'(lsu_rdy), 32'(m_grant() == 2'b10));
      check("idle", 32'(idle), 32'(m_idle()));
      check("rd_wren", 32'(rd_wren), 32'(m_wren));
      if (m_wren) begin
        check("rd_addr", 32'(rd_addr), 32'(m_addr));
        check("rd_data", rd_data, m_data);
      end
      if (rd_wren === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("commit_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("commit_order", {rd_addr, rd_data[26:0]}, {e[36:32], e[26:0]});
        end
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_issue(input logic v, input logic u1, input logic [4:0] rs1,
                             input logic u2, input logic [4:0] rs2,
                             input logic w, input logic [4:0] rd);
    iss_v = v; iss_u1 = u1; iss_rs1 = rs1; iss_u2 = u2; iss_rs2 = rs2;
    iss_w = w; iss_rd = rd;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_v = v; alu_rd = rd; alu_dat = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_v = v; lsu_rd = rd; lsu_dat = d;
  endtask

  // ---------------------------------------------------------------- stimulus
  bit exp_alu_seq[3] = '{1'b1, 1'b0, 1'b1};
  bit ga, gl;

  initial begin
    // Reset then idle
    #3;
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_wren", 32'(rd_wren), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_data", rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    #1;
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_ready", 32'(iss_rdy), 32'd1);

    // Contention from reset: ALU first, then LSU
    drive_alu(1, 5'd3, 32'h0000_0033);
    drive_lsu(1, 5'd4, 32'h0000_0044);
    #1;
    check("cont_alu_first", 32'(alu_rdy), 32'd1);
    check("cont_lsu_wait", 32'(lsu_rdy), 32'd0);
    step();
    drive_alu(0, 5'd0, 32'd0);
    #1;
    check("cont_lsu_next", 32'(lsu_rdy), 32'd1);
    check("cont_commit3_en", 32'(rd_wren), 32'd1);
    check("cont_commit3_addr", 32'(rd_addr), 32'd3);
    step();
    drive_lsu(0, 5'd0, 32'd0);
    #1;
    check("cont_commit4_addr", 32'(rd_addr), 32'd4);
    check("cont_commit4_data", rd_data, 32'h0000_0044);

    // Sustained contention alternates ALU, LSU, ALU
    drive_alu(1, 5'd1, 32'hA0);
    drive_lsu(1, 5'd2, 32'hB0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("alt_alu", 32'(alu_rdy), 32'(exp_alu_seq[k]));
      check("alt_lsu", 32'(lsu_rdy), 32'(!exp_alu_seq[k]));
      ga = alu_rdy;
      step();
      if (ga) alu_dat = alu_dat + 1;
      else lsu_dat = lsu_dat + 1;
    end
    drive_alu(0, 0, 0);
    drive_lsu(0, 0, 0);
    step();

    // RAW stall and release
    drive_issue(1, 0, 0, 0, 0, 1, 5'd5);
    #1;
    check("raw_first_ready", 32'(iss_rdy), 32'd1);
    step();
    drive_issue(1, 1, 5'd5, 0, 0, 0, 0);
    drive_alu(1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("raw_stall", 32'(iss_rdy), 32'd0);
    check("raw_alu_grant", 32'(alu_rdy), 32'd1);
    step();
    drive_alu(0, 0, 0);
    #1;
    check("raw_commit_en", 32'(rd_wren), 32'd1);
    check("raw_commit_addr", 32'(rd_addr), 32'd5);
    check("raw_commit_data", rd_data, 32'hDEAD_BEEF);
    check("raw_still_stall", 32'(iss_rdy), 32'd0);
    step();
    #1;
    check("raw_release", 32'(iss_rdy), 32'd1);
    step();
    drive_issue(0, 0, 0, 0, 0, 0, 0);

    // x0 handling
    drive_issue(1, 0, 0, 0, 0, 1, 5'd0);
    step();
    drive_issue(1, 1, 5'd0, 0, 0, 0, 0);
    drive_lsu(1, 5'd0, 32'h5);
    #1;
    check("x0_ready", 32'(iss_rdy), 32'd1);
    check("x0_lsu_grant", 32'(lsu_rdy), 32'd1);
    step();
    drive_lsu(0, 0, 0);
    drive_issue(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("x0_no_wren", 32'(rd_wren), 32'd0);

    // Set and clear of r7 on the same edge: set wins
    drive_alu(1, 5'd7, 32'h77);
    #1;
    check("col_alu_grant", 32'(alu_rdy), 32'd1);
    step();
    drive_alu(0, 0, 0);
    drive_issue(1, 0, 0, 0, 0, 1, 5'd7);
    #1;
    check("col_commit7", 32'(rd_addr), 32'd7);
    check("col_issue_ok", 32'(iss_rdy), 32'd1);
    step();
    drive_issue(1, 0, 0, 1, 5'd7, 0, 0);
    #1;
    check("col_rs2_stall", 32'(iss_rdy), 32'd0);
    drive_alu(1, 5'd7, 32'h78);
    step();
    drive_alu(0, 0, 0);
    step();
    #1;
    check("col_rs2_free", 32'(iss_rdy), 32'd1);
    drive_issue(0, 0, 0, 0, 0, 0, 0);

    // Flush clears busy, suppresses issue, lets the late writeback land
    drive_issue(1, 0, 0, 0, 0, 1, 5'd2);
    step();
    drive_issue(1, 0, 0, 0, 0, 1, 5'd9);
    step();
    flush = 1;
    drive_alu(1, 5'd2, 32'h22);
    drive_issue(1, 0, 0, 0, 0, 1, 5'd11);
    #1;
    check("fl_alu_grant", 32'(alu_rdy), 32'd1);
    step();
    flush = 0;
    drive_alu(0, 0, 0);
    drive_issue(0, 1, 5'd2, 1, 5'd9, 1, 5'd11);
    #1;
    check("fl_busy_clear", 32'(iss_rdy), 32'd1);
    check("fl_commit_addr", 32'(rd_addr), 32'd2);
    check("fl_commit_data", rd_data, 32'h22);
    step();
    drive_issue(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("fl_idle", 32'(idle), 32'd1);

    // Async reset in the middle of a commit
    drive_alu(1, 5'd6, 32'h66);
    step();
    drive_alu(0, 0, 0);
    #1;
    check("ar_commit_live", 32'(rd_wren), 32'd1);
    rst_n = 0;
    #1;
    check("ar_wren_drop", 32'(rd_wren), 32'd0);
    check("ar_addr_zero", 32'(rd_addr), 32'd0);
    check("ar_idle", 32'(idle), 32'd1);
    step();
    step();
    rst_n = 1;
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ga = alu_rdy;
      gl = lsu_rdy;
      step();
      if (!alu_v || ga) drive_alu($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      if (!lsu_v || gl) drive_lsu($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      drive_issue($urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 19) == 0);
    end

    // Drain
    @(negedge clk);
    step();
    drive_alu(0, 0, 0);
    drive_lsu(0, 0, 0);
    drive_issue(0, 0, 0, 0, 0, 0, 0);
    flush = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Sits in front of the 32x32 RV32I register file and owns its single write port.
- Keeps a per-register busy scoreboard. Issue is stalled on RAW/WAW hazards against writes still in flight.
- Round-robin arbitrates two writeback requesters (ALU, LSU) onto the write port, with a registered commit.
- The decode/issue stage consumes o_issue_ready. Regfile write pins are driven from o_rd_*.

Parameters:
- XLEN, 32, data width of writeback payload and regfile
- NREG, 32, number of architectural registers
- AW, 5, register address width (clog2(NREG))

Ports:
- i_clk  input  1  clock
- i_reset  input  1  reset, asynchronous, active-low
- i_flush  input  1  synchronous pipeline flush; clears scoreboard
- i_issue_valid  input  1  decode presents an instruction
- i_issue_rs1  input  AW  source 1 address
- i_issue_rs2  input  AW  source 2 address
- i_issue_use_rs1  input  1  rs1 is read
- i_issue_use_rs2  input  1  rs2 is read
- i_issue_wren  input  1  instruction writes rd
- i_issue_rd  input  AW  destination address
- o_issue_ready  output  1  no hazard; issue accepted when valid&ready
- i_alu_wb_valid  input  1  ALU writeback request
- i_alu_wb_rd  input  AW  ALU destination
- i_alu_wb_data  input  XLEN  ALU result
- o_alu_wb_ready  output  1  ALU request granted this cycle
- i_lsu_wb_valid  input  1  LSU writeback request
- i_lsu_wb_rd  input  AW  LSU destination
- i_lsu_wb_data  input  XLEN  load data
- o_lsu_wb_ready  output  1  LSU request granted this cycle
- o_rd_wren  output  1  regfile write enable
- o_rd_addr  output  AW  regfile write address
- o_rd_data  output  XLEN  regfile write data
- o_idle  output  1  scoreboard empty and no commit pending

Behaviour:
- Reset (async, i_reset=0):
  - busy vector cleared to 0.
  - RR pointer set to "ALU first".
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - o_idle=1 during and after reset. Reset mid-operation discards all in-flight state; there is no replay.
- Scoreboard:
  - busy[NREG-1:0]; busy[0] is permanently 0.
  - Hazard = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (wren & rd!=0 & busy[rd]).
  - o_issue_ready = !hazard. It is combinational and independent of i_issue_valid.
  - Set: on issue_valid & ready & wren & rd!=0, set busy[rd] at the clock edge.
  - Clear: when o_rd_wren=1, clear busy[o_rd_addr] at the same edge the regfile captures the data. A dependent instruction becomes ready the following cycle, with the value already readable. No forwarding.
  - Same edge, same register, set and clear: set wins.
  - Hazard check uses registered busy only. A clear in progress does not unblock issue in that cycle.
- Arbitration (combinational grant):
  - Only one valid: that source is granted.
  - Both valid: grant the source not granted last. The pointer updates to the granted source on every grant.
  - The ready output equals the grant. Requesters hold valid and payload stable until ready.
- Commit (1-cycle latency): on a grant, o_rd_wren/addr/data register the granted payload at the next edge. With no grant, o_rd_wren=0 and addr/data hold their previous value.
- Writeback with rd=0 is granted (consumed) but produces o_rd_wren=0.
- Flush:
  - On i_flush=1, busy clears to 0 at the edge, overriding same-cycle sets.
  - Arbitration and any pending commit are unaffected; late writebacks still reach the regfile.
  - Issue is not accepted during a flush cycle; the busy set is suppressed.
- o_idle = (busy==0) & !o_rd_wren & !i_alu_wb_valid & !i_lsu_wb_valid.

Decomposition:
- Shared package rv32_pkg:
  - XLEN, NREG, AW constants.
  - typedef wb_req_t {valid, rd, data}.
  - enum wb_src_e {SRC_ALU, SRC_LSU}.
- Sub-module rr_arb2: 2-requester round-robin arbiter with pointer flop, one-hot grant out. Scoreboard and commit register stay in the top.

Test Plan:
- Reset then idle:
  - Expect o_idle=1, o_issue_ready=1, o_rd_wren=0, all busy 0.
- RAW stall:
  - Issue rd=5, wren=1.
  - Next cycle issue rs1=5 -> ready=0.
  - ALU wb rd=5 data=0xDEADBEEF granted cycle N -> o_rd_wren=1 addr=5 cycle N+1 -> ready=1 cycle N+2.
- Contention:
  - ALU rd=3 and LSU rd=4 valid together from reset -> ALU granted first, LSU next cycle.
  - Repeat with both valid -> grants alternate ALU, LSU, ALU.
- x0 handling:
  - Issue rd=0 -> no busy set, following rs1=0 ready=1.
  - LSU wb rd=0 -> ready=1, o_rd_wren stays 0.
- Set/clear collision:
  - busy[7]=1 with commit of rd=7 on the same edge as a new issue rd=7 -> busy[7] remains 1.
  - Issue rs2=7 stalls.
- Flush and async reset:
  - busy{2,9} set, i_flush=1 -> both clear, and a pending ALU wb rd=2 still commits.
  - Assert i_reset=0 mid-commit -> o_rd_wren drops to 0 immediately.
